// File: rtl/app_cmd_sched.sv
// Purpose : sequences one 3-word SATA command into a transport DMA request, gates its data phase, then waits for device status.
// Latency : request is raised 1 cycle after the third command word; data paths are combinational while transferring; done/err pulse in the status/abort cycle.
// Backpressure: data valid/ready pass straight through between user and transport; command port stalls while a command is in flight.
//
// Ports:
//   clk, rst (async, active-low), sata_link_up
//   command_s_axi_*  : 3-word command input (w0 write/sectors, w1 LBA lo, w2 LBA hi + tlast)
//   write_s_axi_*    : user write data in      read_m_axi_* : user read data out (tlast on final word)
//   tp_cmd_*         : request to transport     tp_wr_* / tp_rd_* : transport data  tp_status_* : device status
//   busy, done, err, err_code : progress and completion reporting
module app_cmd_sched #(
    parameter int WORDS_PER_SECTOR = 128,
    parameter int TIMEOUT_CYCLES   = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sata_link_up,
    input  logic        command_s_axi_tvalid,
    input  logic        command_s_axi_tlast,
    output logic        command_s_axi_tready,
    input  logic [31:0] command_s_axi_tdata,
    input  logic        write_s_axi_tvalid,
    output logic        write_s_axi_tready,
    input  logic [31:0] write_s_axi_tdata,
    output logic        read_m_axi_tvalid,
    input  logic        read_m_axi_tready,
    output logic [31:0] read_m_axi_tdata,
    output logic        read_m_axi_tlast,
    output logic        tp_cmd_req,
    input  logic        tp_cmd_ack,
    output logic        tp_cmd_write,
    output logic [47:0] tp_cmd_lba,
    output logic [15:0] tp_cmd_count,
    output logic        tp_wr_valid,
    input  logic        tp_wr_ready,
    output logic [31:0] tp_wr_data,
    input  logic        tp_rd_valid,
    output logic        tp_rd_ready,
    input  logic [31:0] tp_rd_data,
    input  logic        tp_status_valid,
    input  logic        tp_status_err,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);
    localparam int SHIFT = $clog2(WORDS_PER_SECTOR);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CW1     = 3'd1;
    localparam logic [2:0] S_CW2     = 3'd2;
    localparam logic [2:0] S_ISSUE   = 3'd3;
    localparam logic [2:0] S_XFER    = 3'd4;
    localparam logic [2:0] S_WAIT_ST = 3'd5;

    logic [2:0]    state, state_nx;
    logic          armed;      // keeps the command port closed while held in reset
    logic          flush;      // discarding the tail of a rejected command
    logic [23:0]   wcnt;
    logic [TW-1:0] tmo_cnt;

    logic cmd_hs, xfer_act, wr_act, rd_act, data_hs, last_word, tmo_hit, timed;
    logic err_c, done_c, start, flush_set, flush_clr;
    logic [1:0] code_c;

    assign cmd_hs    = command_s_axi_tvalid & command_s_axi_tready;
    assign xfer_act  = (state == S_XFER) & sata_link_up;
    assign wr_act    = xfer_act & tp_cmd_write;
    assign rd_act    = xfer_act & ~tp_cmd_write;
    assign data_hs   = (wr_act & write_s_axi_tvalid & tp_wr_ready) |
                       (rd_act & tp_rd_valid & read_m_axi_tready);
    assign last_word = (wcnt == 24'd1);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);
    assign timed     = (state == S_ISSUE) | (state == S_XFER) | (state == S_WAIT_ST);

    always_comb begin
        state_nx  = state;
        err_c     = 1'b0;
        code_c    = 2'd0;
        done_c    = 1'b0;
        start     = 1'b0;
        flush_set = 1'b0;
        flush_clr = 1'b0;
        if (state != S_IDLE && !sata_link_up) begin
            err_c    = 1'b1;
            code_c   = 2'd3;
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (cmd_hs) begin
                    if (flush) begin
                        flush_clr = command_s_axi_tlast;
                    end else begin
                        start = 1'b1;
                        if (command_s_axi_tdata[15:0] == 16'd0 || command_s_axi_tlast) begin
                            err_c     = 1'b1;
                            code_c    = 2'd1;
                            flush_set = ~command_s_axi_tlast;
                        end else begin
                            state_nx = S_CW1;
                        end
                    end
                end
                S_CW1: if (cmd_hs) begin
                    if (command_s_axi_tlast) begin
                        err_c    = 1'b1;
                        code_c   = 2'd1;
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_CW2;
                    end
                end
                S_CW2: if (cmd_hs) begin
                    if (!command_s_axi_tlast) begin
                        err_c     = 1'b1;
                        code_c    = 2'd1;
                        flush_set = 1'b1;
                        state_nx  = S_IDLE;
                    end else begin
                        state_nx = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (tp_cmd_ack) begin
                        state_nx = S_XFER;
                    end else if (tmo_hit) begin
                        err_c    = 1'b1;
                        code_c   = 2'd2;
                        state_nx = S_IDLE;
                    end
                end
                S_XFER: begin
                    // Status before the last word means the device gave up early.
                    if (tp_status_valid) begin
                        err_c    = 1'b1;
                        code_c   = 2'd1;
                        state_nx = S_IDLE;
                    end else if (data_hs && last_word) begin
                        state_nx = S_WAIT_ST;
                    end else if (!data_hs && tmo_hit) begin
                        err_c    = 1'b1;
                        code_c   = 2'd2;
                        state_nx = S_IDLE;
                    end
                end
                S_WAIT_ST: begin
                    if (tp_status_valid) begin
                        done_c   = ~tp_status_err;
                        err_c    = tp_status_err;
                        code_c   = tp_status_err ? 2'd1 : 2'd0;
                        state_nx = S_IDLE;
                    end else if (tmo_hit) begin
                        err_c    = 1'b1;
                        code_c   = 2'd2;
                        state_nx = S_IDLE;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            armed        <= 1'b0;
            flush        <= 1'b0;
            tp_cmd_write <= 1'b0;
            tp_cmd_count <= 16'd0;
            tp_cmd_lba   <= 48'd0;
            wcnt         <= 24'd0;
            tmo_cnt      <= '0;
            err_code     <= 2'd0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
            if (flush_set)      flush <= 1'b1;
            else if (flush_clr) flush <= 1'b0;
            if (start) begin
                tp_cmd_write <= command_s_axi_tdata[31];
                tp_cmd_count <= command_s_axi_tdata[15:0];
                wcnt         <= 24'(command_s_axi_tdata[15:0]) << SHIFT;
            end else if (data_hs) begin
                wcnt <= wcnt - 24'd1;
            end
            if (state == S_CW1 && cmd_hs) tp_cmd_lba[31:0]  <= command_s_axi_tdata;
            if (state == S_CW2 && cmd_hs) tp_cmd_lba[47:32] <= command_s_axi_tdata[15:0];
            // Idle timer restarts on every state change and every data beat.
            if (state_nx != state || data_hs) tmo_cnt <= '0;
            else if (timed)                   tmo_cnt <= tmo_cnt + TW'(1);
            if (err_c)      err_code <= code_c;
            else if (start) err_code <= 2'd0;
        end
    end

    always_comb begin
        command_s_axi_tready = 1'b0;
        if (state == S_IDLE)                      command_s_axi_tready = armed & (flush | sata_link_up);
        else if (state == S_CW1 || state == S_CW2) command_s_axi_tready = 1'b1;
    end

    assign tp_cmd_req         = (state == S_ISSUE) & sata_link_up;
    assign tp_wr_valid        = wr_act & write_s_axi_tvalid;
    assign write_s_axi_tready = wr_act & tp_wr_ready;
    assign tp_wr_data         = wr_act ? write_s_axi_tdata : 32'd0;
    assign read_m_axi_tvalid  = rd_act & tp_rd_valid;
    assign tp_rd_ready        = rd_act & read_m_axi_tready;
    assign read_m_axi_tdata   = rd_act ? tp_rd_data : 32'd0;
    assign read_m_axi_tlast   = rd_act & last_word;
    assign busy               = (state != S_IDLE);
    assign done               = done_c;
    assign err                = err_c;
endmodule
